// File: rtl/store_buffer_if.sv
// Processor-side and dmem-side signal bundle for the posted-write store buffer.
interface store_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  // Processor data-memory port
  logic            cpu_we;
  logic            cpu_re;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic [DW-1:0]   cpu_rdata;
  logic            stall;

  // Single-port dmem
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  // Occupancy status
  logic [CntW-1:0] count;
  logic            empty;

  // Processor/dmem side (drives requests and dmem read data)
  modport master (
    output cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, stall, mem_we, mem_addr, mem_wdata, count, empty
  );

  // Store buffer side
  modport slave (
    input  cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, stall, mem_we, mem_addr, mem_wdata, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer between the processor data port and a single-port dmem.
// Stores enqueue in one cycle and drain one per cycle when dmem is not needed
// by a load; loads forward from the youngest matching buffered store.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned WaW  = AW - 2;

  typedef struct packed {
    logic [WaW-1:0] waddr;
    logic [DW-1:0]  data;
  } entry_t;

  entry_t            entry_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;

  logic              full_c;
  logic              enq_c;
  logic              drain_c;
  logic              fwd_hit_c;
  logic [DW-1:0]     fwd_data_c;
  logic [PtrW-1:0]   fwd_idx_c;
  logic [WaW-1:0]    cpu_waddr_c;

  assign cpu_waddr_c = bus.cpu_addr[AW-1:2];

  // Accept/drain decisions: loads own the dmem port, full buffer refuses stores
  always_comb begin
    full_c  = (count_q == CntW'(DEPTH));
    enq_c   = bus.cpu_we & ~full_c;
    drain_c = (count_q != '0) & ~bus.cpu_re;
  end

  // Next-state for pointers, valid bits and occupancy counter
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (enq_c) begin
      tail_d          = tail_q + PtrW'(1);
      valid_d[tail_q] = 1'b1;
    end
    if (drain_c) begin
      head_d          = head_q + PtrW'(1);
      valid_d[head_q] = 1'b0;
    end
    case ({enq_c, drain_c})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards any pending stores
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload; qualified by valid_q so it needs no reset
  always_ff @(posedge clk) begin
    if (enq_c) begin
      entry_q[tail_q] <= '{waddr: cpu_waddr_c, data: bus.cpu_wdata};
    end
  end

  // Forwarding search oldest-to-youngest so the youngest match wins
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    fwd_idx_c  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx_c = head_q + PtrW'(i);
      if (valid_q[fwd_idx_c] && (entry_q[fwd_idx_c].waddr == cpu_waddr_c)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = entry_q[fwd_idx_c].data;
      end
    end
  end

  // Combinational processor-side and dmem-side outputs
  always_comb begin
    bus.cpu_rdata = fwd_hit_c ? fwd_data_c : bus.mem_rdata;
    bus.stall     = bus.cpu_we & full_c;
    bus.mem_we    = drain_c;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = '0;
    if (drain_c) begin
      bus.mem_addr  = {entry_q[head_q].waddr, 2'b00};
      bus.mem_wdata = entry_q[head_q].data;
    end
    bus.count = count_q;
    bus.empty = (count_q == '0);
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: driver computes expectations from a
// queue-based model of buffered stores, monitor compares on the falling edge.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();
  store_buffer    #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
  } st_t;

  typedef struct {
    int          cnt;
    bit          stall;
    bit          mwe;
    bit          re;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic [31:0] rdata;
  } exp_t;

  st_t         mq[$];      // model: buffered stores, oldest first
  st_t         wr_q[$];    // expected dmem write order
  exp_t        exp_q[$];   // expected per-cycle outputs
  logic [31:0] ref_mem [256];
  logic [31:0] dmem    [256];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] init_val(int i);
    return (i == 9) ? 32'h0000_5555 : (32'hA000_0000 | 32'(i));
  endfunction

  // dmem: combinational read, write on rising edge, preloaded during reset
  assign bus.mem_rdata = dmem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_val(i);
    end else if (bus.mem_we) begin
      dmem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One processor cycle: drive inputs, predict outputs, advance the model
  task automatic step(bit we, bit re, logic [31:0] addr, logic [31:0] wd);
    exp_t e;
    bit   hit;
    bus.cpu_we    = we;
    bus.cpu_re    = re;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    e.cnt   = mq.size();
    e.stall = we && (mq.size() == DEPTH);
    e.mwe   = (mq.size() != 0) && !re;
    e.re    = re;
    e.maddr = e.mwe ? {mq[0].wa, 2'b00} : addr;
    e.mdata = e.mwe ? mq[0].d : 32'h0;
    e.rdata = ref_mem[addr[9:2]];
    hit = 1'b0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!hit && mq[i].wa == addr[31:2]) begin
        e.rdata = mq[i].d;
        hit     = 1'b1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (e.mwe) begin
      ref_mem[mq[0].wa[7:0]] = mq[0].d;
      mq.delete(0);
    end
    if (we && !e.stall) begin
      mq.push_back('{wa: addr[31:2], d: wd});
      wr_q.push_back('{wa: addr[31:2], d: wd});
    end
  endtask

  task automatic clear_model();
    mq.delete();
    wr_q.delete();
    exp_q.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_count"}, 32'(bus.count), 32'h0);
    check({tag, "_empty"}, 32'(bus.empty), 32'h1);
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'h0);
    check({tag, "_stall"}, 32'(bus.stall), 32'h0);
  endtask

  // Monitor: compare DUT outputs with the oldest expectation, score dmem writes
  always @(negedge clk) begin
    exp_t e;
    st_t  w;
    if (reset) begin
      assert (!(bus.cpu_we && bus.cpu_re));
      check("count_le_depth", 32'(bus.count <= DEPTH), 32'h1);
      check("empty_vs_count", 32'(bus.empty), 32'(bus.count == 0));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", 32'(bus.count), 32'(e.cnt));
        check("empty", 32'(bus.empty), 32'(e.cnt == 0));
        check("stall", 32'(bus.stall), 32'(e.stall));
        check("mem_we", 32'(bus.mem_we), 32'(e.mwe));
        check("mem_addr", bus.mem_addr, e.maddr);
        check("mem_wdata", bus.mem_wdata, e.mdata);
        if (e.re) check("cpu_rdata", bus.cpu_rdata, e.rdata);
      end
      if (bus.mem_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_dmem_write", bus.mem_addr, 32'hFFFF_FFFF);
        end else begin
          w = wr_q.pop_front();
          check("drain_addr", bus.mem_addr, {w.wa, 2'b00});
          check("drain_data", bus.mem_wdata, w.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [31:0] a;
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    reset = 1'b0;
    clear_model();

    // Reset held three cycles, then idle
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 0, 32'h30, 32'h0);
    step(0, 0, 32'h44, 32'h0);

    // Single store then drain
    step(1, 0, 32'h10, 32'hDEAD_BEEF);
    step(0, 0, 32'h0,  32'h0);
    step(0, 0, 32'h0,  32'h0);

    // Back-to-back stores
    for (int i = 0; i < 6; i++) step(1, 0, 32'(i * 4), 32'hC0DE_0000 + 32'(i));
    step(0, 0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 32'h0);

    // Forwarding of the youngest store; low address bits ignored
    step(1, 0, 32'h20, 32'h1111);
    step(0, 1, 32'h20, 32'h0);
    step(1, 0, 32'h20, 32'h2222);
    step(0, 1, 32'h20, 32'h0);
    step(0, 1, 32'h22, 32'h0);
    step(0, 1, 32'h24, 32'h0);
    step(0, 0, 32'h0,  32'h0);

    // Loads block draining; drain resumes after the load window
    step(1, 0, 32'h40, 32'h4040_4040);
    repeat (3) step(0, 1, 32'h40, 32'h0);
    step(0, 0, 32'h0, 32'h0);
    step(0, 1, 32'h40, 32'h0);

    // Reset asserted between edges with stores pending
    step(1, 0, 32'h50, 32'h5050);
    step(1, 0, 32'h54, 32'h5454);
    step(1, 0, 32'h58, 32'h5858);
    #2;
    reset = 1'b0;
    clear_model();
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) step(0, 0, 32'h58, 32'h0);
    step(0, 1, 32'h58, 32'h0);

    // Randomized mix of stores, loads and idle cycles
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if (r < 4)      step(1, 0, a, $urandom);
      else if (r < 7) step(0, 1, a, 32'h0);
      else            step(0, 0, a, 32'h0);
    end
    repeat (3) step(0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("leftover_writes", 32'(wr_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
